// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding fetch at a time, a single-entry
// output buffer towards the decoder, and redirect/kill handling for
// in-flight requests and responses.
module ifu #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid_o,
  input  logic                  imem_req_ready_i,
  output logic [ADDR_WIDTH-1:0] imem_req_addr_o,
  input  logic                  imem_rsp_valid_i,
  input  logic [INST_WIDTH-1:0] imem_rsp_data_i,
  input  logic                  imem_rsp_err_i,
  input  logic                  redirect_valid_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic [INST_WIDTH-1:0] instr_ifu_o,
  output logic [ADDR_WIDTH-1:0] pc_ifu_o,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic                  fetch_err_o
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic                    kill_q, kill_d;
  logic                    valid_q, valid_d;
  logic [INST_WIDTH-1:0]   instr_q, instr_d;
  logic [ADDR_WIDTH-1:0]   pcout_q, pcout_d;
  logic                    err_q, err_d;
  logic [ADDR_WIDTH-1:0]   redirect_tgt;
  logic [ADDR_WIDTH-1:0]   pc_inc;

  // Redirect targets are word aligned; the low two bits are dropped.
  assign redirect_tgt = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
  assign pc_inc       = pc_q + {{(ADDR_WIDTH-3){1'b0}}, 3'd4};

  // Request valid is masked by rst so nothing is requested while reset is held.
  assign imem_req_valid_o = (state_q == S_REQ) && !rst;
  assign imem_req_addr_o  = pc_q;
  assign instr_ifu_o      = instr_q;
  assign pc_ifu_o         = pcout_q;
  assign instr_valid_o    = valid_q;
  assign fetch_err_o      = err_q;

  // Next-state logic: fetch sequencing, redirect handling and output buffer load.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    kill_d  = kill_q;
    valid_d = valid_q;
    instr_d = instr_q;
    pcout_d = pcout_q;
    err_d   = err_q;
    unique case (state_q)
      S_REQ: begin
        if (imem_req_ready_i) begin
          state_d = S_WAIT;
          // Accepted request already targets the old path; its response must be dropped.
          if (redirect_valid_i) kill_d = 1'b1;
        end
        if (redirect_valid_i) pc_d = redirect_tgt;
      end
      S_WAIT: begin
        if (imem_rsp_valid_i) begin
          if (kill_q || redirect_valid_i) begin
            state_d = S_REQ;
            kill_d  = 1'b0;
          end else begin
            state_d = S_HOLD;
            valid_d = 1'b1;
            instr_d = imem_rsp_data_i;
            pcout_d = pc_q;
            err_d   = imem_rsp_err_i;
          end
        end else if (redirect_valid_i) begin
          kill_d = 1'b1;
        end
        if (redirect_valid_i) pc_d = redirect_tgt;
      end
      S_HOLD: begin
        if (redirect_valid_i) begin
          state_d = S_REQ;
          valid_d = 1'b0;
          pc_d    = redirect_tgt;
        end else if (instr_ready_i) begin
          state_d = S_REQ;
          valid_d = 1'b0;
          pc_d    = pc_inc;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  // State and output-buffer registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      kill_q  <= 1'b0;
      valid_q <= 1'b0;
      instr_q <= '0;
      pcout_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      pcout_q <= pcout_d;
      err_q   <= err_d;
    end
  end

endmodule
